// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller states, the S-box table
// and the small byte/word helpers used by the key schedule and the round datapath.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Entry 255 holds S(8'h00) so that the table literal reads in FIPS-197 order.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[~b];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/encrypt_round.sv
// One full AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey);
// MixColumns is bypassed on the final round.
module encrypt_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         is_final_round,
  output logic [127:0] state_out
);

  // Byte i of the state sits at [127-8i -: 8]; row = i%4, column = i/4.
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    // NOTE: every array element is written on every pass, so no latch can be inferred.
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (is_final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/key_expand_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and the round constant. Purely combinational.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_in;
  assign rot = rot_word(w3);
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign n0 = w0 ^ sub ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, key schedule on the fly.
// Define AES_PERF_CNT_EN to add the completed-block counter (blk_count / cnt_clr).
module aes128_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_PERF_CNT_EN
  ,
  input  logic         cnt_clr,
  output logic [31:0]  blk_count
`endif
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes128_encrypt_ctrl: NR must be 10 for AES-128");
  end

  localparam logic [3:0] NR_L = NR[3:0];

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;

  logic [127:0] next_rk;
  logic [127:0] round_out;
  logic         is_final;

  assign is_final = (rnd_q == NR_L);

  key_expand_step u_key_expand_step (
    .rk_in  (rk_q),
    .rcon   (rcon_q),
    .rk_out (next_rk)
  );

  encrypt_round u_encrypt_round (
    .state_in       (st_q),
    .round_key      (next_rk),
    .is_final_round (is_final),
    .state_out      (round_out)
  );

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rcon_d      = rcon_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        // in_ready_q is only ever high while idle, so it alone qualifies the accept.
        if (in_valid && in_ready_q) begin
          st_d    = in_data ^ in_key;
          rk_d    = in_key;
          rcon_d  = 8'h01;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d   = round_out;
        rk_d   = next_rk;
        rcon_d = xtime(rcon_q);
        if (is_final) begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so in_ready stays low during reset and rises on the first edge after it.
    in_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rcon_q      <= 8'h01;
      rnd_q       <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rcon_q      <= rcon_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ROUND);

`ifdef AES_PERF_CNT_EN
  logic [31:0] blk_count_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      blk_count_q <= '0;
    end else if (state_q == DONE && out_ready) begin
      blk_count_q <= blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Directed bench for aes128_encrypt_ctrl with a ciphertext scoreboard fed at
// stimulus time and drained by a negedge monitor on the output handshake.
module tb_aes128_encrypt_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] S_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] S_CT   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_PERF_CNT_EN
  logic         cnt_clr;
  logic [31:0]  blk_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_edge  = 0;
  int acc_before;
  logic out_valid_prev = 1'b0;

  logic [127:0] sb_q[$];
  int           acc_q[$];
  int           acc_hist[$];

  aes128_encrypt_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES_PERF_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: latency of each block and scoreboard compare on the output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_hist.push_back(cyc + 1);
      end
      if (out_valid && !out_valid_prev) begin
        check("accept_pending", 128'(acc_q.size() != 0), 128'(1));
        if (acc_q.size() != 0) check("latency", 128'(cyc - acc_q.pop_front()), 128'(10));
      end
      if (out_valid && out_ready) begin
        hs_edge = cyc + 1;
        check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) check("ciphertext", out_data, sb_q.pop_front());
      end
    end
    out_valid_prev = out_valid;
  end

  task automatic offer(input logic [127:0] key, input logic [127:0] pt,
                       input logic [127:0] exp, input bit keep);
    in_key   = key;
    in_data  = pt;
    in_valid = 1'b1;
    sb_q.push_back(exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = ~pt;
      in_key   = ~key;
    end
  endtask

  task automatic wait_out(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("out_valid_timeout", 128'(out_valid), 128'(1));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check("drain", 128'(sb_q.size()), 128'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
`ifdef AES_PERF_CNT_EN
    cnt_clr   = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    // C.1 with 20 cycles of backpressure; B is offered meanwhile and must wait
    offer(C1_KEY, C1_PT, C1_CT, 1'b0);
    check("busy_in_round", 128'(busy), 128'(1));
    wait_out(20);
    acc_before = acc_hist.size();
    in_key   = B_KEY;
    in_data  = B_PT;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, C1_CT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    check("bp_busy", 128'(busy), 128'(0));
    check("bp_no_accept", 128'(acc_hist.size()), 128'(acc_before));
    out_ready = 1'b1;
    offer(B_KEY, B_PT, B_CT, 1'b0);
    check("accept_after_handshake", 128'(acc_hist[acc_hist.size()-1]), 128'(hs_edge + 1));
    check("out_data_held", out_data, C1_CT);
    out_ready = 1'b0;
    wait_out(20);
    check("b_round10_key", dut.rk_q, B_RK10);
    out_ready = 1'b1;
    drain(10);

    // Back-to-back with in_valid and out_ready held high
    offer(C1_KEY, C1_PT, C1_CT, 1'b1);
    offer(B_KEY, S_PT, S_CT, 1'b0);
    check("b2b_accept_spacing",
          128'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 128'(12));
    drain(30);

    // Reset in round 5 discards the block
    offer(B_KEY, B_PT, B_CT, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    acc_q.delete();
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_in_ready_low", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_output", 128'(out_valid), 128'(0));
    end
    offer(C1_KEY, C1_PT, C1_CT, 1'b0);
    drain(30);

`ifdef AES_PERF_CNT_EN
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt_cleared", 128'(blk_count), 128'(0));
    offer(C1_KEY, C1_PT, C1_CT, 1'b0);
    offer(B_KEY, B_PT, B_CT, 1'b0);
    offer(B_KEY, S_PT, S_CT, 1'b0);
    drain(30);
    check("cnt_three", 128'(blk_count), 128'(3));
    out_ready = 1'b0;
    offer(C1_KEY, C1_PT, C1_CT, 1'b0);
    wait_out(20);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt_clr_priority", 128'(blk_count), 128'(0));
    check("cnt_clr_handshake_done", 128'(out_valid), 128'(0));
    drain(5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_ctrl.md
Name: aes128_encrypt_ctrl

Overview:
Iterative AES-128 encryption engine controller that owns one encrypt_round instance and drives it for 10 clock cycles per block. It performs the initial AddRoundKey and generates each round key on the fly. It also moves blocks in and out over valid/ready handshakes. It sits between the host-side plaintext/key source and the ciphertext consumer; one block is in flight at a time.

Parameters:
NR, 10, number of rounds; fixed at 10 for AES-128; any other value is a synthesis-time error.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext/key offered
in_ready  output  1  controller can accept a block
in_data  input  128  plaintext, FIPS-197 byte order, byte 0 at [127:120]
in_key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_data  output  128  ciphertext, same byte order
busy  output  1  high in ROUND state

Behaviour:
- Reset is synchronous: rst high at a rising edge forces state IDLE, round counter 0, rcon 8'h01, out_valid 0, out_data 0, busy 0. in_ready is 1 from the first edge after rst deasserts. rst mid-block discards the block with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register st<=in_data^in_key, rk<=in_key, rcon<=8'h01, rnd<=1, then go to ROUND.
  - ROUND: in_ready=0, busy=1.
    - Combinational next_rk=key_expand_step(rk,rcon). encrypt_round inputs: in=st, key=next_rk, is_final_round=(rnd==NR).
    - Each edge: st<=round output, rk<=next_rk, rcon<=xtime(rcon), where xtime is a left shift XOR 8'h1b if msb was set. rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
    - When rnd==NR: out_data<=round output, out_valid<=1, go to DONE. Otherwise rnd<=rnd+1.
  - DONE: out_valid=1, out_data stable, in_ready=0. On out_ready, clear out_valid and go to IDLE.
- Latency: accept edge E, out_valid high after edge E+10. Throughput is one block per 12 cycles minimum, with out_ready tied high.
- out_data holds its last ciphertext after the handshake until the next block completes.
- in_data/in_key are sampled only at the accept edge; later changes are ignored.
- out_ready high outside DONE has no effect. in_valid outside IDLE is not accepted and must be held by the source.
- rnd is a 4-bit counter and never exceeds NR.

Optional Feature:
- Macro: AES_PERF_CNT_EN.
- When defined:
  - Adds output blk_count[31:0], counting completed out handshakes.
  - Reset value 0; wraps 32'hFFFFFFFF->0.
  - Adds input cnt_clr (1 bit); cnt_clr zeroes the counter and takes priority over a same-cycle increment.
- When undefined: neither port exists and no counter logic is built. Core behaviour is identical either way.

Decomposition:
- Package aes_pkg contains:
  - localparam AES_NR=10
  - FSM state enum {IDLE, ROUND, DONE}
  - function xtime(8-bit)
  - function sbox(8-bit), the shared S-box table
  - function rot_word
- Sub-module key_expand_step, which is combinational:
  - Ports: rk_in[127:0], rcon[7:0], rk_out[127:0].
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Built from 4 sbox() calls.
- The controller instantiates one encrypt_round and one key_expand_step.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 edges after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; internal rk after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 20 cycles after C.1 completes -> out_valid and out_data stable, in_ready=0; the next in_valid is accepted only after the out handshake.
- Back-to-back: two blocks, in_valid and out_ready tied high -> second ciphertext correct; accepts 12 cycles apart.
- Reset mid-block: assert rst at round 5 for 1 cycle -> no out_valid; in_ready=1 next cycle; the following block encrypts correctly.
- AES_PERF_CNT_EN: 3 blocks -> blk_count=3; cnt_clr coincident with a handshake -> 0.
